key_expansion_256: RTL and testbench
====================================

# key_expansion_256

Generates the fifteen 128-bit AES-256 round keys from a 256-bit cipher key and writes them, one per cycle, into the round-key memory (`keymem`). It drives that memory's write port and valid-clear input directly. It is the upstream stage of `keymem`, and the encrypt and decrypt round engines read their keys from that memory. It produces one round key per clock using four instances of the existing combinational `aes_sbox` (8-bit in, 8-bit out).

## Interface
Parameters: none.

Clock and reset: one clock; reset is asynchronous and active-high.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request expansion; accepted only in IDLE
- key  input  256  cipher key, sampled on the accepted start edge; key[255:224] is FIPS word w0
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle completion pulse
- clr_valid  output  1  to keymem reset_valid_bits; one-cycle pulse
- w_en  output  1  to keymem w_en
- waddr  output  4  to keymem waddr; values 0..14
- wkey  output  128  to keymem wkey; wkey[127:96] is word w(4k) of round key k

## Operation
- Registered state: state (IDLE, CLR, GEN, DONE), rk_m2 and rk_m1 (128 bits each), cnt (4 bits), rcon (8 bits). All outputs are registered or decoded from state.
- Reset, asynchronous: state=IDLE, cnt=0, rcon=8'h01, rk_m2=rk_m1=0. All outputs are 0: busy, done, clr_valid, w_en, waddr=0, wkey=0.
- IDLE, when start=1:
  - rk_m2 <= key[255:128] (rk0); rk_m1 <= key[127:0] (rk1).
  - cnt <= 0; rcon <= 8'h01; next state CLR.
- CLR: clr_valid=1 for exactly one cycle, w_en=0. Next state GEN.
  - This is a separate cycle because keymem gives reset_valid_bits priority over w_en.
- GEN: w_en=1 and waddr=cnt every cycle. wkey by cnt:
  - cnt=0: wkey = rk_m2.
  - cnt=1: wkey = rk_m1.
  - cnt>=2: wkey = rk_new, defined below.
  - When cnt>=2, after the write: rk_m2 <= rk_m1, rk_m1 <= rk_new.
  - When cnt=14: next state DONE. Otherwise cnt <= cnt+1.
- rk_new (for cnt=k>=2, with p=rk_m1[31:0] and rk_m2 split into words q0..q3, MSW first):
  - k even: t = SubWord(RotWord(p)) ^ {rcon,24'h0}; after the write, rcon <= rcon<<1.
  - k odd: t = SubWord(p).
  - w0 = q0^t, w1 = q1^w0, w2 = q2^w1, w3 = q3^w2. rk_new = {w0,w1,w2,w3}.
  - RotWord({a,b,c,d}) = {b,c,d,a}. SubWord applies aes_sbox to each byte.
- rcon takes the values 01,02,04,08,10,20,40 for k = 2,4,…,14. Its maximum is 8'h40, so no reduction by the AES polynomial is needed.
- DONE: done=1 for one cycle, w_en=0. Next state IDLE.
- start while busy is ignored, and key is not resampled.
- Reset mid-operation: immediate return to IDLE with outputs zero. keymem entries already written stay valid; clearing them is keymem's job. The next start issues clr_valid again.

## Timing
- Start accepted at edge E0.
- clr_valid high in cycle E0+1.
- w_en high in cycles E0+2 … E0+16, with waddr 0 … 14 in order.
- done high in cycle E0+17. State is IDLE from E0+18, and a new start is accepted on the edge ending the E0+18 cycle.
- Total 18 cycles from start acceptance to done deassertion. busy is high in cycles E0+1 … E0+17.
- Outputs w_en, waddr and wkey are stable for a whole cycle and valid at the rising edge, which is when keymem captures them.
- Combinational critical path: one S-box plus a 4-deep 32-bit XOR chain.

## Test plan
- Reset behaviour: assert reset asynchronously in the middle of a cycle → every output reads 0 immediately. start held high during reset → no action.
- FIPS-197 A.3 key 603deb10…0914dff4:
  - waddr 0 gets key[255:128]; waddr 1 gets key[127:0].
  - waddr 2 gets 9ba354118e6925afa51a8b5f2067fcde.
  - waddr 3 gets a8b09c1a93d194cdbe49846eb75d5b9a.
  - waddr 14 gets fe4890d1e6188d0b046df344706c631e.
  - done at E0+17.
- All-zero key: waddr 0 and 1 get 0; waddr 2 gets 62636363 in all four words; waddr 3 gets aafbfbfb in all four words.
- start pulsed again at E0+5 with a different key → ignored. All 15 writes match the first key, and exactly one clr_valid pulse occurs.
- Reset at E0+8, then a fresh start → clr_valid is reasserted and the full sequence of 15 writes restarts at waddr 0.
- Back-to-back runs: start asserted continuously → a second run begins the cycle after the first run returns to IDLE. Check with keymem attached that valid_bits reads 0x7FFF after each done.

Source files
------------

// File: rtl/key_expansion_256.sv
// AES-256 key expansion: writes the fifteen 128-bit round keys into keymem,
// one per cycle, after a one-cycle valid-bit clear.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   start      request expansion (accepted only in IDLE)
//   key        256-bit cipher key, key[255:224] is word w0
//   busy       high whenever not IDLE
//   done       one-cycle completion pulse
//   clr_valid  one-cycle pulse to keymem reset_valid_bits
//   w_en       keymem write enable
//   waddr      keymem write address, 0..14
//   wkey       keymem write data, wkey[127:96] is w(4k)
module key_expansion_256 (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [255:0] key,
  output logic         busy,
  output logic         done,
  output logic         clr_valid,
  output logic         w_en,
  output logic [3:0]   waddr,
  output logic [127:0] wkey
);

  localparam int unsigned RK_W   = 128;
  localparam int unsigned WORD_W = 32;
  localparam logic [3:0]  LAST_IDX = 4'd14;

  typedef enum logic [1:0] {IDLE, CLR, GEN, DONE} state_t;

  state_t            state;
  logic [RK_W-1:0]   rk_m2;
  logic [RK_W-1:0]   rk_m1;
  logic [3:0]        cnt;
  logic [7:0]        rcon;

  logic [3:0]        nxt_idx;
  logic [WORD_W-1:0] sub_w;
  logic [WORD_W-1:0] t_w;
  logic [WORD_W-1:0] w0, w1, w2, w3;
  logic [RK_W-1:0]   rk_new;

  // Outputs are registered one cycle ahead, so the key computed here is the
  // one presented in the next cycle (index cnt+1).
  assign nxt_idx = cnt + 4'd1;

  // SubWord on the last word of the previous round key
  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .din  (rk_m1[8*b +: 8]),
      .dout (sub_w[8*b +: 8])
    );
  end

  // Next round key; RotWord commutes with the bytewise S-box, so it is
  // applied after substitution.
  always_comb begin
    t_w = sub_w;
    if (!nxt_idx[0]) begin
      t_w = {sub_w[23:0], sub_w[31:24]} ^ {rcon, 24'h000000};
    end
    w0     = rk_m2[127:96] ^ t_w;
    w1     = rk_m2[95:64]  ^ w0;
    w2     = rk_m2[63:32]  ^ w1;
    w3     = rk_m2[31:0]   ^ w2;
    rk_new = {w0, w1, w2, w3};
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rk_m2     <= '0;
      rk_m1     <= '0;
      cnt       <= '0;
      rcon      <= 8'h01;
      busy      <= 1'b0;
      done      <= 1'b0;
      clr_valid <= 1'b0;
      w_en      <= 1'b0;
      waddr     <= '0;
      wkey      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            rk_m2     <= key[255:128];
            rk_m1     <= key[127:0];
            cnt       <= '0;
            rcon      <= 8'h01;
            busy      <= 1'b1;
            clr_valid <= 1'b1;
            state     <= CLR;
          end
        end
        CLR: begin
          // keymem prioritises the valid clear over writes, hence this gap
          clr_valid <= 1'b0;
          w_en      <= 1'b1;
          waddr     <= '0;
          wkey      <= rk_m2;
          state     <= GEN;
        end
        GEN: begin
          if (cnt == LAST_IDX) begin
            w_en  <= 1'b0;
            waddr <= '0;
            wkey  <= '0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt   <= nxt_idx;
            waddr <= nxt_idx;
            if (nxt_idx == 4'd1) begin
              wkey <= rk_m1;
            end else begin
              wkey  <= rk_new;
              rk_m2 <= rk_m1;
              rk_m1 <= rk_new;
              if (!nxt_idx[0]) begin
                rcon <= {rcon[6:0], 1'b0};
              end
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// AES S-box: multiplicative inverse in GF(2^8) mod x^8+x^4+x^3+x+1,
// followed by the FIPS-197 affine transform. Purely combinational.
//
// Ports:
//   din   input byte
//   dout  substituted byte
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = '0;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // inv = din^254 = din^(2+4+...+128); maps 0 to 0 as AES requires
  always_comb begin
    sq  = din;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    dout = inv
         ^ {inv[6:0], inv[7]}
         ^ {inv[5:0], inv[7:6]}
         ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]}
         ^ 8'h63;
  end

endmodule

// File: tb/tb_key_expansion_256.sv
// Directed bench for key_expansion_256 with a small keymem valid-bit model.
module tb_key_expansion_256;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [255:0] key;
  logic         busy, done, clr_valid, w_en;
  logic [3:0]   waddr;
  logic [127:0] wkey;

  key_expansion_256 dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .key       (key),
    .busy      (busy),
    .done      (done),
    .clr_valid (clr_valid),
    .w_en      (w_en),
    .waddr     (waddr),
    .wkey      (wkey)
  );

  always #5 clk = ~clk;

  localparam logic [255:0] FIPS_KEY =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] ZERO_KEY = 256'h0;

  int nvec = 0;
  int nerr = 0;

  logic [127:0] wr_key [16];
  int           wr_cyc [16];
  int           nwr, nclr, ndone;
  int           clr_cyc  [4];
  int           done_cyc [4];
  logic [14:0]  valid;
  logic [14:0]  valid_at_done [4];
  logic [40:0]  busy_vec;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"},  128'(busy),      128'd0);
    chk({tag, "_done"},  128'(done),      128'd0);
    chk({tag, "_clr"},   128'(clr_valid), 128'd0);
    chk({tag, "_wen"},   128'(w_en),      128'd0);
    chk({tag, "_waddr"}, 128'(waddr),     128'd0);
    chk({tag, "_wkey"},  wkey,            128'd0);
  endtask

  // Issue start with key k, then sample ncyc cycles (index i = cycle E0+i).
  task automatic run(input logic [255:0] k, input int ncyc, input int pulse_at,
                     input logic [255:0] k2, input bit hold, input int reset_at);
    nwr = 0; nclr = 0; ndone = 0; busy_vec = '0;
    for (int a = 0; a < 16; a++) begin
      wr_key[a] = 'x;
      wr_cyc[a] = -1;
    end
    @(negedge clk);
    key   = k;
    start = 1'b1;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      busy_vec[i] = busy;
      if (clr_valid) begin
        if (nclr < 4) clr_cyc[nclr] = i;
        nclr++;
        valid = '0;
      end
      if (w_en) begin
        wr_key[waddr] = wkey;
        wr_cyc[waddr] = i;
        nwr++;
        if (waddr < 4'd15) valid[waddr] = 1'b1;
      end
      if (done) begin
        if (ndone < 4) begin
          done_cyc[ndone]      = i;
          valid_at_done[ndone] = valid;
        end
        ndone++;
      end
      start = hold;
      if (i == pulse_at) begin
        start = 1'b1;
        key   = k2;
      end
      if (i == reset_at) begin
        #1 reset = 1'b1;
        #1 chk_outputs_zero("mid_reset");
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b1;
    key   = FIPS_KEY;
    valid = '0;

    // reset with start held high: nothing happens
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("reset");
    start = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", 128'(busy), 128'd0);

    // FIPS-197 A.3
    run(FIPS_KEY, 18, -1, ZERO_KEY, 1'b0, -1);
    chk("fips_nclr",   128'(nclr),       128'd1);
    chk("fips_clrcyc", 128'(clr_cyc[0]), 128'd1);
    chk("fips_nwr",    128'(nwr),        128'd15);
    for (int a = 0; a < 15; a++) chk("fips_order", 128'(wr_cyc[a]), 128'(a + 2));
    chk("fips_rk0",  wr_key[0],  FIPS_KEY[255:128]);
    chk("fips_rk1",  wr_key[1],  FIPS_KEY[127:0]);
    chk("fips_rk2",  wr_key[2],  128'h9ba354118e6925afa51a8b5f2067fcde);
    chk("fips_rk3",  wr_key[3],  128'ha8b09c1a93d194cdbe49846eb75d5b9a);
    chk("fips_rk14", wr_key[14], 128'hfe4890d1e6188d0b046df344706c631e);
    chk("fips_ndone",   128'(ndone),       128'd1);
    chk("fips_donecyc", 128'(done_cyc[0]), 128'd17);
    chk("fips_busy",    128'(busy_vec[18:1]), 128'(18'h1ffff));

    // all-zero key
    run(ZERO_KEY, 18, -1, ZERO_KEY, 1'b0, -1);
    chk("zero_rk0", wr_key[0], 128'h0);
    chk("zero_rk1", wr_key[1], 128'h0);
    chk("zero_rk2", wr_key[2], 128'h62636363626363636263636362636363);
    chk("zero_rk3", wr_key[3], 128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb);

    // start with another key while busy is ignored
    run(FIPS_KEY, 18, 5, ZERO_KEY, 1'b0, -1);
    chk("ign_nclr",  128'(nclr), 128'd1);
    chk("ign_nwr",   128'(nwr),  128'd15);
    chk("ign_rk0",   wr_key[0],  FIPS_KEY[255:128]);
    chk("ign_rk1",   wr_key[1],  FIPS_KEY[127:0]);
    chk("ign_rk2",   wr_key[2],  128'h9ba354118e6925afa51a8b5f2067fcde);
    chk("ign_rk3",   wr_key[3],  128'ha8b09c1a93d194cdbe49846eb75d5b9a);
    chk("ign_rk14",  wr_key[14], 128'hfe4890d1e6188d0b046df344706c631e);
    chk("ign_donecyc", 128'(done_cyc[0]), 128'd17);

    // reset at E0+8, start held during reset, then a fresh run
    run(FIPS_KEY, 18, -1, ZERO_KEY, 1'b0, 8);
    start = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_hold_busy", 128'(busy), 128'd0);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    run(ZERO_KEY, 18, -1, ZERO_KEY, 1'b0, -1);
    chk("restart_nclr",   128'(nclr),       128'd1);
    chk("restart_clrcyc", 128'(clr_cyc[0]), 128'd1);
    chk("restart_nwr",    128'(nwr),        128'd15);
    chk("restart_wa0cyc", 128'(wr_cyc[0]),  128'd2);
    chk("restart_rk2", wr_key[2], 128'h62636363626363636263636362636363);
    chk("restart_rk3", wr_key[3], 128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb);

    // back-to-back runs with start held high
    valid = 15'h7a5a;
    run(FIPS_KEY, 35, -1, ZERO_KEY, 1'b1, -1);
    chk("b2b_nclr",    128'(nclr),        128'd2);
    chk("b2b_clrcyc1", 128'(clr_cyc[1]),  128'd19);
    chk("b2b_ndone",   128'(ndone),       128'd2);
    chk("b2b_done0",   128'(done_cyc[0]), 128'd17);
    chk("b2b_done1",   128'(done_cyc[1]), 128'd35);
    chk("b2b_valid0",  128'(valid_at_done[0]), 128'h7fff);
    chk("b2b_valid1",  128'(valid_at_done[1]), 128'h7fff);
    chk("b2b_rk14",    wr_key[14], 128'hfe4890d1e6188d0b046df344706c631e);
    repeat (2) @(negedge clk);
    chk("b2b_idle", 128'(busy), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
